ahb_iopmp_log: RTL and testbench

//   Violation logger downstream of the AHB IOPMP. Consumes per-port blocked-transfer

---
 rtl/ahb_iopmp_log_if.sv | 21 ++
 rtl/ahb_iopmp_log.sv | 138 +++++++++++++
 tb/tb_ahb_iopmp_log.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ahb_iopmp_log_if.sv
// AHB-lite config port bundle for the IOPMP violation logger.
// Handshake: a transfer starts in the cycle hsel & htrans[1] is high (address phase);
// hready is always 1, so the data phase is the next cycle and never stalls.
interface ahb_iopmp_log_if #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
);
  logic               hsel;
  logic [A_WIDTH-1:0] haddr;
  logic [1:0]         htrans;
  logic               hwrite;
  logic [D_WIDTH-1:0] hwdata;
  logic [1:0]         hresp;
  logic               hready;
  logic [D_WIDTH-1:0] hrdata;

  modport master (output hsel, haddr, htrans, hwrite, hwdata,
                  input  hresp, hready, hrdata);
  modport slave  (input  hsel, haddr, htrans, hwrite, hwdata,
                  output hresp, hready, hrdata);
endinterface

// File: rtl/ahb_iopmp_log.sv
// Time-stamps blocked-transfer events from two IOPMP ports into a FIFO that
// software drains over AHB-lite (read HEAD_*, then write POP).
module ahb_iopmp_log #(
  parameter int A_WIDTH  = 32,
  parameter int D_WIDTH  = 32,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic               hclk,
  input  logic               hresetn,
  ahb_iopmp_log_if.slave     bus,
  input  logic               v0_valid,
  input  logic [A_WIDTH-1:0] v0_addr,
  input  logic               v0_write,
  input  logic               v1_valid,
  input  logic [A_WIDTH-1:0] v1_addr,
  input  logic               v1_write,
  output logic               irq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [A_WIDTH-1:0]  mem_addr [DEPTH];
  logic                mem_write[DEPTH];
  logic                mem_port [DEPTH];
  logic [TS_WIDTH-1:0] mem_ts   [DEPTH];

  logic [PW-1:0]       rd_ptr, wr_ptr, wr_ptr1;
  logic [CW-1:0]       count, count_nxt, free;
  logic [15:0]         drop_cnt, drop_nxt;
  logic [16:0]         drop_sum;
  logic [TS_WIDTH-1:0] ts;
  logic                en, irq_en, en_nxt, irq_en_nxt;
  logic                wr_pend;
  logic [7:0]          wr_sel;
  logic                ctrl_wr, pop_wr, clr, pop, empty, full;
  logic                req0, req1, acc0, acc1;
  logic [1:0]          n_push, drops;
  logic [D_WIDTH-1:0]  rd_data;
  logic                unused_bits;

  assign bus.hresp   = 2'b00;
  assign bus.hready  = 1'b1;
  assign unused_bits = ^{bus.haddr[A_WIDTH-1:8], bus.htrans[0], bus.hwdata[D_WIDTH-1:3]};

  // A write latched in the previous address phase completes now, using hwdata.
  assign ctrl_wr = wr_pend && (wr_sel == 8'h00);
  assign pop_wr  = wr_pend && (wr_sel == 8'h10);
  assign clr     = ctrl_wr && bus.hwdata[1];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = pop_wr && !empty;
  assign req0    = en && v0_valid;
  assign req1    = en && v1_valid;
  assign wr_ptr1 = wr_ptr + PW'(1);

  // A pop frees its slot for a push landing in the same cycle; port 0 wins the last slot.
  always_comb begin
    free       = CW'(DEPTH) - count + CW'(pop);
    acc0       = req0 && (free != '0);
    acc1       = req1 && (free >= (acc0 ? CW'(2) : CW'(1)));
    n_push     = {1'b0, acc0} + {1'b0, acc1};
    drops      = {1'b0, req0 && !acc0} + {1'b0, req1 && !acc1};
    drop_sum   = {1'b0, drop_cnt} + 17'(drops);
    drop_nxt   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    count_nxt  = count + CW'(n_push) - CW'(pop);
    en_nxt     = ctrl_wr ? bus.hwdata[0] : en;
    irq_en_nxt = ctrl_wr ? bus.hwdata[2] : irq_en;
    if (clr) begin
      count_nxt = '0;
      drop_nxt  = '0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.haddr[7:0])
      8'h00: rd_data = D_WIDTH'({irq_en, 1'b0, en});
      8'h04: rd_data = {drop_cnt, 8'(count), 5'b0, irq, full, empty};
      8'h08: rd_data = empty ? '0 : D_WIDTH'(mem_addr[rd_ptr]);
      8'h0C: rd_data = empty ? '0 :
                       {16'(mem_ts[rd_ptr]), 14'b0, mem_write[rd_ptr], mem_port[rd_ptr]};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ts         <= '0;
      wr_pend    <= 1'b0;
      wr_sel     <= '0;
      bus.hrdata <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_cnt   <= '0;
      en         <= 1'b0;
      irq_en     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      ts       <= ts + TS_WIDTH'(1);
      wr_pend  <= bus.hsel && bus.htrans[1] && bus.hwrite;
      wr_sel   <= bus.haddr[7:0];
      if (bus.hsel && bus.htrans[1] && !bus.hwrite)
        bus.hrdata <= rd_data;
      en       <= en_nxt;
      irq_en   <= irq_en_nxt;
      count    <= count_nxt;
      drop_cnt <= drop_nxt;
      irq      <= irq_en_nxt && (count_nxt != '0);
      if (clr) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        wr_ptr <= wr_ptr + PW'(n_push);
      end
    end
  end

  // Storage needs no reset: HEAD reads are gated by empty.
  always_ff @(posedge hclk) begin
    if (!clr) begin
      if (acc0) begin
        mem_addr[wr_ptr]  <= v0_addr;
        mem_write[wr_ptr] <= v0_write;
        mem_port[wr_ptr]  <= 1'b0;
        mem_ts[wr_ptr]    <= ts;
      end
      if (acc1) begin
        mem_addr[acc0 ? wr_ptr1 : wr_ptr]  <= v1_addr;
        mem_write[acc0 ? wr_ptr1 : wr_ptr] <= v1_write;
        mem_port[acc0 ? wr_ptr1 : wr_ptr]  <= 1'b1;
        mem_ts[acc0 ? wr_ptr1 : wr_ptr]    <= ts;
      end
    end
  end
endmodule

// File: tb/tb_ahb_iopmp_log.sv
// Directed bench for ahb_iopmp_log: config access, push/pop ordering, overflow,
// enable/clear and asynchronous reset.
module tb_ahb_iopmp_log;
  logic        clk = 1'b0;
  logic        hresetn = 1'b0;
  logic        v0_valid = 1'b0, v0_write = 1'b0;
  logic        v1_valid = 1'b0, v1_write = 1'b0;
  logic [31:0] v0_addr = '0, v1_addr = '0;
  logic        irq;
  logic [15:0] cyc;
  int          checks = 0;
  int          errors = 0;

  ahb_iopmp_log_if #(.A_WIDTH(32), .D_WIDTH(32)) bus ();

  ahb_iopmp_log #(.A_WIDTH(32), .D_WIDTH(32), .DEPTH(8), .TS_WIDTH(16)) dut (
    .hclk(clk), .hresetn(hresetn), .bus(bus),
    .v0_valid(v0_valid), .v0_addr(v0_addr), .v0_write(v0_write),
    .v1_valid(v1_valid), .v1_addr(v1_addr), .v1_write(v1_write),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference timestamp: cycles since reset release.
  always @(posedge clk or negedge hresetn)
    if (!hresetn) cyc <= '0;
    else          cyc <= cyc + 16'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b1; bus.haddr = 32'(a);
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hwdata = d;
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b0; bus.haddr = 32'(a);
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    d = bus.hrdata;
  endtask

  task automatic pulse(input logic p0, input logic [31:0] a0, input logic w0,
                       input logic p1, input logic [31:0] a1, input logic w1,
                       output logic [15:0] t);
    @(negedge clk);
    v0_valid = p0; v0_addr = a0; v0_write = w0;
    v1_valid = p1; v1_addr = a1; v1_write = w1;
    t = cyc;
    @(negedge clk);
    v0_valid = 1'b0; v1_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] t;
    logic [31:0] exp_q[$];
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0;
    bus.haddr = '0; bus.hwdata = '0;
    repeat (3) @(negedge clk);
    hresetn = 1'b1;

    check("reset_irq", 32'(irq), 32'd0);
    check("reset_hrdata", bus.hrdata, 32'd0);
    check("reset_hready_hresp", {29'd0, bus.hready, bus.hresp}, 32'd4);
    rd(8'h04, d); check("reset_stat", d, 32'h0000_0001);
    rd(8'h08, d); check("reset_head_addr", d, 32'h0);

    wr(8'h00, 32'h5);
    check("en_irq_idle", 32'(irq), 32'd0);
    pulse(1'b1, 32'h4000_0010, 1'b1, 1'b0, 32'h0, 1'b0, t);
    check("irq_after_push", 32'(irq), 32'd1);
    rd(8'h08, d); check("head_addr_single", d, 32'h4000_0010);
    rd(8'h0C, d); check("head_info_single", d, {t, 14'd0, 2'b10});
    rd(8'h04, d); check("stat_one", d, 32'h0000_0104);
    wr(8'h10, 32'h0);
    check("irq_after_pop", 32'(irq), 32'd0);
    rd(8'h04, d); check("stat_after_pop", d, 32'h0000_0001);

    pulse(1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, t);
    rd(8'h04, d); check("stat_dual", d, 32'h0000_0204);
    rd(8'h08, d); check("dual_head0_addr", d, 32'h100);
    rd(8'h0C, d); check("dual_head0_info", d, {t, 16'h0000});
    wr(8'h10, 32'h0);
    rd(8'h08, d); check("dual_head1_addr", d, 32'h200);
    rd(8'h0C, d); check("dual_head1_info", d, {t, 16'h0001});
    wr(8'h10, 32'h0);
    rd(8'h04, d); check("dual_drained", d, 32'h0000_0001);

    for (int i = 0; i < 10; i++) begin
      pulse(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 32'h0, 1'b0, t);
      if (i < 8) exp_q.push_back(32'h1000 + 32'(i * 4));
    end
    rd(8'h04, d); check("stat_full_drops", d, 32'h0002_0806);
    rd(8'h08, d); check("full_head", d, 32'h1000);

    // POP data phase and a port-1 event on the same edge.
    @(negedge clk);
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b1; bus.haddr = 32'h10;
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hwdata = 32'h0;
    v1_valid = 1'b1; v1_addr = 32'h3000; v1_write = 1'b1;
    @(negedge clk);
    v1_valid = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(32'h3000);
    rd(8'h04, d); check("stat_pop_push_full", d, 32'h0002_0806);

    for (int i = 0; i < 8; i++) begin
      rd(8'h08, d); check($sformatf("drain_%0d", i), d, exp_q.pop_front());
      if (i == 7) begin
        rd(8'h0C, d); check("drain_last_info", d & 32'h3, 32'h3);
      end
      wr(8'h10, 32'h0);
    end
    rd(8'h04, d); check("stat_drained", d, 32'h0002_0001);
    check("irq_drained", 32'(irq), 32'd0);

    wr(8'h00, 32'h4);
    pulse(1'b1, 32'h5000, 1'b0, 1'b1, 32'h6000, 1'b0, t);
    rd(8'h04, d); check("stat_en0_ignored", d, 32'h0002_0001);
    check("irq_en0", 32'(irq), 32'd0);

    wr(8'h00, 32'h5);
    for (int i = 0; i < 3; i++)
      pulse(1'b1, 32'h7000 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0, t);
    rd(8'h04, d); check("stat_three", d, 32'h0002_0304);
    wr(8'h00, 32'h7);
    rd(8'h04, d); check("stat_after_clr", d, 32'h0000_0001);
    check("irq_after_clr", 32'(irq), 32'd0);
    rd(8'h00, d); check("ctrl_readback", d, 32'h5);
    rd(8'h20, d); check("unmapped_read", d, 32'h0);

    pulse(1'b1, 32'h8000, 1'b1, 1'b1, 32'h8004, 1'b0, t);
    check("irq_prereset", 32'(irq), 32'd1);
    @(negedge clk);
    #2 hresetn = 1'b0;
    #1;
    check("async_reset_irq", 32'(irq), 32'd0);
    check("async_reset_hrdata", bus.hrdata, 32'd0);
    @(negedge clk);
    hresetn = 1'b1;
    rd(8'h04, d); check("post_reset_stat", d, 32'h0000_0001);
    rd(8'h00, d); check("post_reset_ctrl", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
